// File: rtl/wb_intercon_n.sv
// Single-master Wishbone interconnect fanning out to N_SLAVE slaves.
// Decode error or timeout ends the transfer with master_ERR.
module wb_intercon_n #(
  parameter int              N_SLAVE  = 8,
  parameter int              DW       = 32,
  parameter int              AW       = 32,
  parameter int              SEL_HI   = 31,
  parameter int              SEL_LO   = 28,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = DW'(32'hFFFF_FFFF)
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  master_STB,
  input  logic                  master_WE,
  input  logic [AW-1:0]         master_ADDR,
  input  logic [DW-1:0]         master_DAT_I,
  output logic [DW-1:0]         master_DAT_O,
  output logic                  master_ACK,
  output logic                  master_ERR,
  output logic [N_SLAVE-1:0]    slave_STB,
  input  logic [N_SLAVE-1:0]    slave_ACK,
  output logic                  slave_WE,
  output logic [AW-1:0]         slave_ADDR,
  input  logic [N_SLAVE*DW-1:0] slave_DAT_I,
  output logic [DW-1:0]         slave_DAT_O,
  output logic [AW-1:0]         err_addr,
  output logic [7:0]            err_cnt,
  output logic                  err_irq
);

  localparam int IW = SEL_HI - SEL_LO + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [31:0]   N_SLAVE_U = 32'(N_SLAVE);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic            we_reg, we_next;
  logic [DW-1:0]   wdat_reg, wdat_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [DW-1:0]   rdat_reg, rdat_next;
  logic [AW-1:0]   err_addr_reg, err_addr_next;
  logic [7:0]      err_cnt_reg, err_cnt_next;
  logic            err_irq_reg, err_irq_next;

  logic [IW-1:0]      req_idx;
  logic               decode_err;
  logic [N_SLAVE-1:0] stb_vec;
  logic [DW-1:0]      rd_masked [N_SLAVE];
  logic [DW-1:0]      rd_sel;
  logic               ack_sel;
  logic [7:0]         err_cnt_inc;

  assign req_idx     = master_ADDR[SEL_HI:SEL_LO];
  assign decode_err  = 32'(req_idx) >= N_SLAVE_U;
  assign err_cnt_inc = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;

  // Strobe and read-data mux are decoded straight from state, so reset drops them at once.
  generate
    for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_slave
      assign stb_vec[gi]   = (state_reg == REQ) && (idx_reg == IW'(gi));
      assign rd_masked[gi] = stb_vec[gi] ? slave_DAT_I[gi*DW +: DW] : '0;
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_SLAVE; k++) rd_sel = rd_sel | rd_masked[k];
  end

  assign ack_sel = |(slave_ACK & stb_vec);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdat_next     = wdat_reg;
    idx_next      = idx_reg;
    timer_next    = timer_reg;
    rdat_next     = rdat_reg;
    err_addr_next = err_addr_reg;
    err_cnt_next  = err_cnt_reg;
    err_irq_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (master_STB) begin
          addr_next  = master_ADDR;
          we_next    = master_WE;
          wdat_next  = master_DAT_I;
          idx_next   = req_idx;
          timer_next = '0;
          if (decode_err) begin
            state_next    = ERR;
            rdat_next     = ERR_DATA;
            err_addr_next = master_ADDR;
            err_cnt_next  = err_cnt_inc;
            err_irq_next  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // Abort beats everything; a real ACK beats a timeout on the same cycle.
        if (!master_STB) begin
          state_next = IDLE;
        end else if (ack_sel) begin
          rdat_next  = rd_sel;
          state_next = RESP;
        end else if ((TIMEOUT != 0) && (timer_reg == T_LAST)) begin
          state_next    = ERR;
          rdat_next     = ERR_DATA;
          err_addr_next = addr_reg;
          err_cnt_next  = err_cnt_inc;
          err_irq_next  = 1'b1;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      RESP, ERR: begin
        if (!master_STB) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdat_reg     <= '0;
      idx_reg      <= '0;
      timer_reg    <= '0;
      rdat_reg     <= '0;
      err_addr_reg <= '0;
      err_cnt_reg  <= '0;
      err_irq_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdat_reg     <= wdat_next;
      idx_reg      <= idx_next;
      timer_reg    <= timer_next;
      rdat_reg     <= rdat_next;
      err_addr_reg <= err_addr_next;
      err_cnt_reg  <= err_cnt_next;
      err_irq_reg  <= err_irq_next;
    end
  end

  assign slave_STB    = stb_vec;
  assign slave_WE     = we_reg;
  assign slave_ADDR   = addr_reg;
  assign slave_DAT_O  = wdat_reg;
  assign master_DAT_O = rdat_reg;
  assign master_ACK   = (state_reg == RESP) || (state_reg == ERR);
  assign master_ERR   = (state_reg == ERR);
  assign err_addr     = err_addr_reg;
  assign err_cnt      = err_cnt_reg;
  assign err_irq      = err_irq_reg;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Randomized and directed bench for wb_intercon_n against a transaction-level model
// of latency, strobe count, error response and error bookkeeping.
module tb_wb_intercon_n;
  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              RSTN = 1'b0;
  logic              master_STB = 1'b0;
  logic              master_WE = 1'b0;
  logic [AW-1:0]     master_ADDR = '0;
  logic [DW-1:0]     master_DAT_I = '0;
  logic [DW-1:0]     master_DAT_O;
  logic              master_ACK, master_ERR;
  logic [NS-1:0]     slave_STB;
  logic [NS-1:0]     slave_ACK = '0;
  logic              slave_WE;
  logic [AW-1:0]     slave_ADDR;
  logic [NS*DW-1:0]  slave_DAT_I = '0;
  logic [DW-1:0]     slave_DAT_O;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_cnt;
  logic              err_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  m_cnt = '0;
  logic [31:0] m_err_addr = '0;
  logic [31:0] sdat [NS];

  always #5 clk = ~clk;

  wb_intercon_n #(.N_SLAVE(NS), .DW(DW), .AW(AW), .SEL_HI(31), .SEL_LO(28),
                  .TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .RSTN(RSTN),
    .master_STB(master_STB), .master_WE(master_WE), .master_ADDR(master_ADDR),
    .master_DAT_I(master_DAT_I), .master_DAT_O(master_DAT_O),
    .master_ACK(master_ACK), .master_ERR(master_ERR),
    .slave_STB(slave_STB), .slave_ACK(slave_ACK), .slave_WE(slave_WE),
    .slave_ADDR(slave_ADDR), .slave_DAT_I(slave_DAT_I), .slave_DAT_O(slave_DAT_O),
    .err_addr(err_addr), .err_cnt(err_cnt), .err_irq(err_irq)
  );

  task automatic load_slave_data();
    for (int k = 0; k < NS; k++) begin
      sdat[k] = $urandom;
      slave_DAT_I[k*DW +: DW] = sdat[k];
    end
  endtask

  function automatic void model_err(input logic [31:0] addr);
    m_cnt      = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
    m_err_addr = addr;
  endfunction

  // Drives one master transfer while acting as every slave: the addressed slave acks
  // in its (delay+1)-th strobe cycle; 'noise' slaves hold ACK high throughout.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int delay, input logic [NS-1:0] noise, input int hold,
                         output int edges, output int stbs, output logic err,
                         output logic [31:0] rdata, output int irqs, output logic latch_ok,
                         output logic hold_ok, output logic after_busy);
    logic [3:0]    sidx;
    logic [NS-1:0] ack_vec;
    sidx = addr[31:28];
    edges = 0; stbs = 0; irqs = 0; err = 1'b0; rdata = '0;
    latch_ok = 1'b1; hold_ok = 1'b1; after_busy = 1'b0;
    master_ADDR = addr; master_WE = we; master_DAT_I = wdata; master_STB = 1'b1;
    slave_ACK = noise;
    forever begin
      @(posedge clk); #1;
      edges++;
      if (err_irq) irqs++;
      if (master_ACK) break;
      if (edges > 400) begin edges = -1; break; end
      ack_vec = noise;
      if (slave_STB != '0) begin
        stbs++;
        if (slave_STB !== (NS'(1) << sidx) || slave_WE !== we ||
            slave_ADDR !== addr || slave_DAT_O !== wdata) latch_ok = 1'b0;
        if (sidx < NS && stbs == delay + 1) ack_vec[sidx[2:0]] = 1'b1;
      end
      slave_ACK = ack_vec;
    end
    err = master_ERR;
    rdata = master_DAT_O;
    slave_ACK = noise;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (err_irq) irqs++;
      if (master_ACK !== 1'b1 || slave_STB !== '0 || master_ERR !== err ||
          master_DAT_O !== rdata) hold_ok = 1'b0;
    end
    master_STB = 1'b0;
    @(posedge clk); #1;
    if (err_irq) irqs++;
    after_busy = master_ACK | master_ERR | (|slave_STB);
    slave_ACK = '0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    #3;
    n_tests++;
    if ({master_ACK, master_ERR, err_irq, slave_STB, slave_WE} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=0", {master_ACK, master_ERR, err_irq, slave_STB, slave_WE});
    end
    n_tests++;
    if ({master_DAT_O, slave_ADDR, slave_DAT_O, err_addr, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_data dat=%h addr=%h wdat=%h eaddr=%h ecnt=%0d want all 0",
               master_DAT_O, slave_ADDR, slave_DAT_O, err_addr, err_cnt);
    end
    @(negedge clk); RSTN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_read_tied();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    load_slave_data();
    sdat[2] = 32'h0000_00AB; slave_DAT_I[2*DW +: DW] = sdat[2];
    run_txn(32'h2000_0010, 1'b0, 32'h0, 0, 8'b0000_0100, 3, e, s, er, rd, irq, lo, ho, ab);
    $display("[TB] read_tied addr=20000010 edges=%0d stbs=%0d data=%h", e, s, rd);
    n_tests++; if (e !== 2 || s !== 1) begin n_fail++; $display("FAIL read_tied_latency edges=%0d stbs=%0d want 2/1", e, s); end
    n_tests++; if (rd !== 32'h0000_00AB || er !== 1'b0) begin n_fail++; $display("FAIL read_tied_data got=%h err=%b want 000000ab/0", rd, er); end
    n_tests++; if (lo !== 1'b1 || ho !== 1'b1 || ab !== 1'b0) begin n_fail++; $display("FAIL read_tied_hold latch=%b hold=%b after=%b want 1/1/0", lo, ho, ab); end
  endtask

  task automatic test_write_delayed();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    run_txn(32'h0000_0004, 1'b1, 32'h1234_5678, 2, '0, 1, e, s, er, rd, irq, lo, ho, ab);
    $display("[TB] write addr=00000004 edges=%0d stbs=%0d", e, s);
    n_tests++; if (s !== 3 || e !== 4) begin n_fail++; $display("FAIL write_latency stbs=%0d edges=%0d want 3/4", s, e); end
    n_tests++; if (lo !== 1'b1 || er !== 1'b0 || ab !== 1'b0 || irq !== 0) begin n_fail++; $display("FAIL write_fields latch=%b err=%b after=%b irq=%0d want 1/0/0/0", lo, er, ab, irq); end
  endtask

  task automatic test_decode_err();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    run_txn(32'hA000_0000, 1'b0, 32'h0, 0, '0, 2, e, s, er, rd, irq, lo, ho, ab);
    model_err(32'hA000_0000);
    $display("[TB] decode_err addr=a0000000 edges=%0d err=%b data=%h", e, er, rd);
    n_tests++; if (e !== 1 || s !== 0 || er !== 1'b1) begin n_fail++; $display("FAIL decode_resp edges=%0d stbs=%0d err=%b want 1/0/1", e, s, er); end
    n_tests++; if (rd !== 32'hFFFF_FFFF || err_addr !== 32'hA000_0000 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL decode_status data=%h eaddr=%h cnt=%0d want ffffffff/a0000000/1", rd, err_addr, err_cnt); end
    n_tests++; if (irq !== 1 || ho !== 1'b1 || ab !== 1'b0) begin n_fail++; $display("FAIL decode_irq pulses=%0d hold=%b after=%b want 1/1/0", irq, ho, ab); end
  endtask

  task automatic test_ignore_other();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    load_slave_data();
    run_txn(32'h3000_0020, 1'b0, 32'h0, 1, 8'b0000_0010, 0, e, s, er, rd, irq, lo, ho, ab);
    $display("[TB] ignore_other addr=30000020 edges=%0d stbs=%0d", e, s);
    n_tests++; if (e !== 3 || s !== 2 || rd !== sdat[3] || er !== 1'b0) begin n_fail++; $display("FAIL ignore_other edges=%0d stbs=%0d data=%h err=%b want 3/2/%h/0", e, s, rd, er, sdat[3]); end
  endtask

  task automatic test_abort();
    logic [7:0] cnt_before;
    cnt_before = err_cnt;
    master_ADDR = 32'h5000_0040; master_WE = 1'b0; master_STB = 1'b1; slave_ACK = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (slave_STB !== 8'b0010_0000) begin n_fail++; $display("FAIL abort_stb got=%b want 00100000", slave_STB); end
    master_STB = 1'b0;
    @(posedge clk); #1;
    $display("[TB] abort addr=50000040 stb=%b ack=%b", slave_STB, master_ACK);
    n_tests++; if ({slave_STB, master_ACK, master_ERR} !== '0 || err_cnt !== m_cnt) begin n_fail++; $display("FAIL abort_idle stb=%b ack=%b err=%b cnt=%0d want 0/0/0/%0d", slave_STB, master_ACK, master_ERR, err_cnt, m_cnt); end
    @(posedge clk); #1;
    n_tests++; if ({slave_STB, master_ACK, err_irq} !== '0 || err_cnt !== cnt_before) begin n_fail++; $display("FAIL abort_quiet stb=%b ack=%b irq=%b cnt=%0d", slave_STB, master_ACK, err_irq, err_cnt); end
  endtask

  task automatic test_timeout();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    load_slave_data();
    run_txn(32'h4000_0100, 1'b0, 32'h0, 1000, '0, 0, e, s, er, rd, irq, lo, ho, ab);
    model_err(32'h4000_0100);
    $display("[TB] timeout addr=40000100 stbs=%0d edges=%0d err=%b", s, e, er);
    n_tests++; if (s !== TO || e !== TO + 1 || er !== 1'b1 || rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timeout_resp stbs=%0d edges=%0d err=%b data=%h want %0d/%0d/1/ffffffff", s, e, er, rd, TO, TO + 1); end
    n_tests++; if (irq !== 1 || err_cnt !== m_cnt || err_addr !== m_err_addr) begin n_fail++; $display("FAIL timeout_status irq=%0d cnt=%0d eaddr=%h want 1/%0d/%h", irq, err_cnt, err_addr, m_cnt, m_err_addr); end
    // Ack on the very last allowed strobe cycle must still complete normally.
    run_txn(32'h4000_0200, 1'b0, 32'h0, TO - 1, '0, 0, e, s, er, rd, irq, lo, ho, ab);
    $display("[TB] ack_at_limit addr=40000200 stbs=%0d err=%b", s, er);
    n_tests++; if (s !== TO || er !== 1'b0 || rd !== sdat[4] || err_cnt !== m_cnt) begin n_fail++; $display("FAIL ack_at_limit stbs=%0d err=%b data=%h cnt=%0d want %0d/0/%h/%0d", s, er, rd, err_cnt, TO, sdat[4], m_cnt); end
  endtask

  task automatic test_random();
    int e, s, irq, delay, e_edges, e_stbs; logic er, lo, ho, ab, e_err, we;
    logic [31:0] rd, addr, wd, e_data; logic [3:0] idx; logic [NS-1:0] noise;
    for (int i = 0; i < 40; i++) begin
      load_slave_data();
      addr  = $urandom;
      idx   = addr[31:28];
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      delay = ($urandom_range(0, 15) == 0) ? 400 : int'($urandom_range(0, 5));
      noise = NS'($urandom);
      if (idx < NS) noise[idx[2:0]] = 1'b0;
      if (idx >= NS) begin
        e_err = 1'b1; e_edges = 1; e_stbs = 0;
      end else if (delay + 1 > TO) begin
        e_err = 1'b1; e_edges = TO + 1; e_stbs = TO;
      end else begin
        e_err = 1'b0; e_edges = delay + 2; e_stbs = delay + 1;
      end
      e_data = e_err ? 32'hFFFF_FFFF : sdat[idx[2:0]];
      if (e_err) model_err(addr);
      run_txn(addr, we, wd, delay, noise, int'($urandom_range(0, 2)), e, s, er, rd, irq, lo, ho, ab);
      $display("[TB] rand %0d addr=%h we=%b delay=%0d edges=%0d err=%b", i, addr, we, delay, e, er);
      n_tests++; if (e !== e_edges || s !== e_stbs || er !== e_err) begin n_fail++; $display("FAIL rand_resp i=%0d edges=%0d stbs=%0d err=%b want %0d/%0d/%b", i, e, s, er, e_edges, e_stbs, e_err); end
      n_tests++; if ((!we || e_err) && rd !== e_data) begin n_fail++; $display("FAIL rand_data i=%0d got=%h want %h", i, rd, e_data); end
      n_tests++; if (irq !== int'(e_err) || lo !== 1'b1 || ho !== 1'b1 || ab !== 1'b0) begin n_fail++; $display("FAIL rand_flags i=%0d irq=%0d latch=%b hold=%b after=%b want %0d/1/1/0", i, irq, lo, ho, ab, int'(e_err)); end
      n_tests++; if (err_cnt !== m_cnt || err_addr !== m_err_addr) begin n_fail++; $display("FAIL rand_status i=%0d cnt=%0d eaddr=%h want %0d/%h", i, err_cnt, err_addr, m_cnt, m_err_addr); end
    end
  endtask

  task automatic test_saturation();
    int e, s, irq, bad; logic er, lo, ho, ab; logic [31:0] rd, addr;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      addr = {4'($urandom_range(8, 15)), 28'($urandom)};
      run_txn(addr, 1'b0, 32'h0, 0, '0, 0, e, s, er, rd, irq, lo, ho, ab);
      model_err(addr);
      if (irq != 1 || er !== 1'b1 || err_cnt !== m_cnt) bad++;
    end
    $display("[TB] saturation cnt=%0d eaddr=%h", err_cnt, err_addr);
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL sat_each bad=%0d want 0", bad); end
    n_tests++; if (err_cnt !== 8'd255 || err_addr !== m_err_addr) begin n_fail++; $display("FAIL sat_final cnt=%0d eaddr=%h want 255/%h", err_cnt, err_addr, m_err_addr); end
  endtask

  task automatic test_reset_mid();
    int e, s, irq; logic er, lo, ho, ab; logic [31:0] rd;
    master_ADDR = 32'h6000_0000; master_WE = 1'b1; master_DAT_I = 32'hCAFE_F00D;
    master_STB = 1'b1; slave_ACK = '0;
    repeat (2) @(posedge clk);
    #2;
    RSTN = 1'b0;
    #1;
    $display("[TB] reset_mid stb=%b cnt=%0d", slave_STB, err_cnt);
    n_tests++; if ({slave_STB, master_ACK, master_ERR, slave_WE} !== '0 || slave_ADDR !== '0 || slave_DAT_O !== '0) begin n_fail++; $display("FAIL reset_mid_bus stb=%b ack=%b we=%b addr=%h want 0", slave_STB, master_ACK, slave_WE, slave_ADDR); end
    n_tests++; if (err_cnt !== 8'd0 || err_addr !== '0) begin n_fail++; $display("FAIL reset_mid_status cnt=%0d eaddr=%h want 0/0", err_cnt, err_addr); end
    m_cnt = '0; m_err_addr = '0;
    master_STB = 1'b0;
    @(negedge clk); RSTN = 1'b1;
    @(posedge clk); #1;
    load_slave_data();
    run_txn(32'h1000_0008, 1'b0, 32'h0, 0, '0, 0, e, s, er, rd, irq, lo, ho, ab);
    $display("[TB] after_reset addr=10000008 edges=%0d data=%h", e, rd);
    n_tests++; if (e !== 2 || rd !== sdat[1] || er !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL after_reset edges=%0d data=%h err=%b cnt=%0d want 2/%h/0/0", e, rd, er, err_cnt, sdat[1]); end
  endtask

  initial begin
    test_reset();
    test_read_tied();
    test_write_delayed();
    test_decode_err();
    test_ignore_other();
    test_abort();
    test_timeout();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
